// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, one bit per cycle.
// Latency: done DATA_W+2 edges after accept (2 edges for divide-by-zero / signed overflow).
// Backpressure: busy stalls the pipeline; requests are ignored while busy or in the done cycle.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [1:0]        ALUOp,
    input  logic [6:0]        Funct7,
    input  logic [2:0]        Funct3,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] Result
);

    localparam int CW = $clog2(DATA_W + 2);
    localparam logic [CW-1:0] CNT_CORR = CW'(DATA_W);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [1:0]          f3_q;
    logic                neg_q, sa_q, special_q;
    logic [DATA_W-1:0]   opa_q, fin_q, result_q;
    logic [2*DATA_W-1:0] acc_q;

    logic                accept, signed_a, signed_b, sa, sb, div0, ovf, special;
    logic [DATA_W-1:0]   mag_a, mag_b, special_res;
    logic [DATA_W:0]     mul_sum, div_tmp, div_sub;
    logic                div_ge;
    logic [2*DATA_W-1:0] iter_nxt, prod_fix;
    logic [DATA_W-1:0]   quo, rem, corr_res;

    assign accept   = (state_q == IDLE) && valid_i && (ALUOp == 2'b10) &&
                      (Funct7 == 7'b0000001) && !flush;
    assign signed_a = Funct3[2] ? !Funct3[0] : (Funct3[1:0] == 2'b01 || Funct3[1:0] == 2'b10);
    assign signed_b = Funct3[2] ? !Funct3[0] : (Funct3[1:0] == 2'b01);
    assign sa       = signed_a && SrcA[DATA_W-1];
    assign sb       = signed_b && SrcB[DATA_W-1];
    assign mag_a    = sa ? -SrcA : SrcA;
    assign mag_b    = sb ? -SrcB : SrcB;
    assign div0     = Funct3[2] && (SrcB == '0);
    assign ovf      = Funct3[2] && !Funct3[0] && (SrcA == MIN_NEG) && (SrcB == '1);
    assign special  = div0 || ovf;

    always_comb begin
        special_res = '0;
        if (div0)
            special_res = Funct3[1] ? SrcA : '1;
        else
            special_res = Funct3[1] ? '0 : SrcA;
    end

    // acc_q holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    assign div_tmp  = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    assign div_sub  = div_tmp - {1'b0, opa_q};
    assign div_ge   = !div_sub[DATA_W];
    assign iter_nxt = (state_q == MUL) ? {mul_sum, acc_q[DATA_W-1:1]}
                                       : {div_ge ? div_sub[DATA_W-1:0] : div_tmp[DATA_W-1:0],
                                          acc_q[DATA_W-2:0], div_ge};

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo      = acc_q[DATA_W-1:0];
    assign rem      = acc_q[2*DATA_W-1:DATA_W];

    always_comb begin
        corr_res = '0;
        if (state_q == MUL)
            corr_res = (f3_q == 2'b00) ? prod_fix[DATA_W-1:0] : prod_fix[2*DATA_W-1:DATA_W];
        else if (f3_q[1])
            corr_res = sa_q ? -rem : rem;
        else
            corr_res = neg_q ? -quo : quo;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = Funct3[2] ? DIV : MUL;
            MUL,
            DIV:     if (flush) state_d = IDLE;
                     else if (cnt_q > CNT_CORR) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // counter: 0..DATA_W-1 iterate, DATA_W sign-correct, DATA_W+1 publish result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            f3_q      <= '0;
            neg_q     <= 1'b0;
            sa_q      <= 1'b0;
            special_q <= 1'b0;
            opa_q     <= '0;
            fin_q     <= '0;
            result_q  <= '0;
            acc_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                f3_q      <= Funct3[1:0];
                neg_q     <= sa ^ sb;
                sa_q      <= sa;
                special_q <= special;
                fin_q     <= special_res;
                cnt_q     <= special ? CNT_CORR : '0;
                opa_q     <= Funct3[2] ? mag_b : mag_a;
                acc_q     <= {{DATA_W{1'b0}}, Funct3[2] ? mag_a : mag_b};
            end else if ((state_q == MUL || state_q == DIV) && !flush) begin
                if (cnt_q < CNT_CORR) begin
                    acc_q <= iter_nxt;
                    cnt_q <= cnt_q + 1'b1;
                end else if (cnt_q == CNT_CORR) begin
                    if (!special_q)
                        fin_q <= corr_res;
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    result_q <= fin_q;
                end
            end
        end
    end

    assign busy   = (state_q == MUL) || (state_q == DIV);
    assign done   = (state_q == DONE);
    assign Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-level behavioural model plus directed literal checks.
// Random phase injects ignored requests while busy and scrambles operands after accept.
module tb_muldiv_unit;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          valid_i = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    ALUOp = 2'b00;
    logic [6:0]    Funct7 = 7'd0;
    logic [2:0]    Funct3 = 3'd0;
    logic [W-1:0]  SrcA = '0;
    logic [W-1:0]  SrcB = '0;
    logic          busy, done;
    logic [W-1:0]  Result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ALUOp(ALUOp), .Funct7(Funct7),
        .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
        .busy(busy), .done(done), .Result(Result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Model: cycles remaining until done, pending result, done flag
    int          m_rem = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_res = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem  = 0;
            m_done = 1'b0;
            m_res  = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_rem > 0) begin
            if (flush) begin
                m_rem = 0;
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1;
                    m_res  = m_pend;
                end
            end
        end else if (valid_i && ALUOp == 2'b10 && Funct7 == 7'b0000001 && !flush) begin
            m_pend = ref_model(Funct3, SrcA, SrcB);
            m_rem  = (Funct3[2] && (SrcB == 0 ||
                     (!Funct3[0] && SrcA == 32'h80000000 && SrcB == 32'hFFFFFFFF))) ? 2 : W + 2;
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_rem > 0});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("result", Result, m_res);
    end

    task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        valid_i = 1'b1;
        ALUOp   = 2'b10;
        Funct7  = 7'b0000001;
        Funct3  = f3;
        SrcA    = a;
        SrcB    = b;
    endtask

    task automatic wait_done(input string name, input bit use_lat, input int lat_exp,
                             input bit use_lit, input logic [31:0] lit, input bit noise);
        int lat, bc;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        SrcA    = $urandom;
        SrcB    = $urandom;
        Funct3  = 3'($urandom);
        lat = 0;
        bc  = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (busy) bc++;
            lat++;
            if (lat > 200) begin
                checks++;
                errors++;
                $display("FAIL %s timeout waiting for done", name);
                valid_i = 1'b0;
                return;
            end
            if (noise) begin
                valid_i = 1'($urandom_range(0, 1));
                Funct3  = 3'($urandom);
                SrcA    = $urandom;
                SrcB    = $urandom;
            end
        end
        valid_i = 1'b0;
        if (use_lat) begin
            chk({name, "_lat"}, 32'(lat), 32'(lat_exp));
            chk({name, "_busycnt"}, 32'(bc), 32'(lat_exp));
        end
        if (use_lit) chk({name, "_res"}, Result, lit);
    endtask

    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input int lat_exp, input logic [31:0] lit);
        @(negedge clk);
        drive_req(f3, a, b);
        wait_done(name, 1'b1, lat_exp, 1'b1, lit, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dcnt;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", Result, 32'd0);

        // release reset and present a request for the very first edge
        rst_n = 1'b1;
        drive_req(3'd0, 32'd7, 32'hFFFFFFFD);
        wait_done("mul", 1'b1, 34, 1'b1, 32'hFFFFFFEB, 1'b0);

        // request in the DONE cycle must be dropped
        drive_req(3'd0, 32'd1, 32'd1);
        @(posedge clk);
        #1 valid_i = 1'b0;
        @(negedge clk);
        chk("done_cycle_req", {31'd0, busy}, 32'd0);

        do_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 34, 32'h40000000);
        do_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFF);
        do_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        34, 32'hFFFFFFFD);
        do_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        34, 32'hFFFFFFFF);
        do_op("divu",   3'd5, 32'd100,      32'd7,        34, 32'd14);
        do_op("div0",   3'd4, 32'h00001234, 32'd0,        2,  32'hFFFFFFFF);
        do_op("remu0",  3'd7, 32'd5,        32'd0,        2,  32'd5);
        do_op("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 2,  32'd0);
        do_op("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 2,  32'h80000000);

        // flush seen on accept+10
        @(negedge clk);
        drive_req(3'd4, 32'd1000, 32'd3);
        @(posedge clk);
        #1 valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_result", Result, 32'h80000000);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("flush_nodone", 32'(dcnt), 32'd0);

        // asynchronous reset mid-operation
        @(negedge clk);
        drive_req(3'd0, 32'd9, 32'd9);
        @(posedge clk);
        #1 valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_result", Result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_req(3'd0, 32'd3, 32'd4);
        wait_done("mul34", 1'b1, 34, 1'b1, 32'd12, 1'b0);

        // non-M R-type request
        @(negedge clk);
        drive_req(3'd0, 32'd3, 32'd4);
        Funct7 = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("nonm_busy", {31'd0, busy}, 32'd0);
        valid_i = 1'b0;

        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            drive_req(3'($urandom), pick(), pick());
            wait_done("rand", 1'b0, 0, 1'b0, 32'd0, 1'b1);
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Parameters
REQ-001 SHALL provide parameter DATA_W, default 32, operand/result width; legal values are even and >= 8.

Interface
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
REQ-004 SHALL have port valid_i, input, 1, request qualifier.
REQ-005 SHALL have port ALUOp, input, 2, controller opcode class (2'b10 = R-type).
REQ-006 SHALL have port Funct7, input, 7, instruction bits 31:25.
REQ-007 SHALL have port Funct3, input, 3, instruction bits 14:12.
REQ-008 SHALL have port SrcA, input, DATA_W, rs1 operand / dividend.
REQ-009 SHALL have port SrcB, input, DATA_W, rs2 operand / divisor.
REQ-010 SHALL have port flush, input, 1, synchronous abort.
REQ-011 SHALL have port busy, output, 1, operation in progress; pipeline stall request.
REQ-012 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-013 SHALL have port Result, output, DATA_W, M-extension result.

Function
REQ-014 SHALL accept a request on a rising edge where state==IDLE, valid_i=1, ALUOp=2'b10 and Funct7=7'b0000001; any other combination SHALL be ignored with no state change.
REQ-015 SHALL decode Funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-016 SHALL register SrcA, SrcB and Funct3 at the accept edge; later input changes SHALL NOT affect the result.
REQ-017 SHALL implement the FSM states IDLE, MUL, DIV, DONE: IDLE->MUL (Funct3[2]=0) or IDLE->DIV (Funct3[2]=1) on accept; MUL/DIV->DONE after DATA_W iterations; DONE->IDLE unconditionally.
REQ-018 SHALL compute multiplies as radix-2 shift-add on operand magnitudes, one bit per cycle, with a 2*DATA_W-bit product and final sign correction.
REQ-019 SHALL take the sign of SrcA for MULH/MULHSU, the sign of SrcB for MULH only, and treat all other multiply operands as unsigned.
REQ-020 SHALL return product[DATA_W-1:0] for MUL and product[2*DATA_W-1:DATA_W] for MULH/MULHSU/MULHU.
REQ-021 SHALL compute divides as restoring division on magnitudes, one quotient bit per cycle.
REQ-022 SHALL give a quotient sign of sign(A) XOR sign(B) and a remainder sign equal to sign(A) for DIV/REM; DIVU/REMU SHALL be unsigned.
REQ-023 SHALL handle divisor==0 without iterating: the quotient SHALL be all-ones and the remainder SHALL be SrcA.
REQ-024 SHALL handle signed overflow (DIV/REM, SrcA=1 followed by zeros, SrcB=all-ones) without iterating: the quotient SHALL be SrcA and the remainder SHALL be 0.
REQ-025 SHALL assert done on the edge N+DATA_W+2 for the normal path, and on edge N+2 for the REQ-023/REQ-024 paths, where N is the accept edge.
REQ-026 SHALL drive busy=1 from the accept edge until the edge that raises done; busy SHALL be 0 while done=1.
REQ-027 SHALL update Result on the same edge that raises done and SHALL hold it stable until the next completion.
REQ-028 SHALL keep done high for exactly one cycle.
REQ-029 SHALL ignore valid_i while busy=1 or in DONE; a request presented in the DONE cycle SHALL NOT be accepted.
REQ-030 On flush=1 in MUL/DIV, SHALL move the FSM to IDLE on the next edge with busy=0, no done pulse, and Result unchanged; flush SHALL have priority over acceptance and completion on the same edge.

Reset
REQ-031 With rst_n=0, SHALL immediately force state=IDLE, busy=0, done=0, Result=0 and clear all iteration counters and operand registers, including mid-operation.
REQ-032 After rst_n deasserts, SHALL be able to accept a request on the first rising edge.

Verification (DATA_W=32)
REQ-033 Bench SHALL cover MUL: A=7, B=0xFFFFFFFD -> Result=0xFFFFFFEB, done on accept+34, busy high 34 cycles.
REQ-034 Bench SHALL cover MULH and MULHSU: MULH A=B=0x80000000 -> 0x40000000; MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-035 Bench SHALL cover signed divide: DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU A=100, B=7 -> 14.
REQ-036 Bench SHALL cover special cases: DIV x/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with done on accept+2; REM 0x80000000 / 0xFFFFFFFF -> 0 and DIV with the same operands -> 0x80000000.
REQ-037 Bench SHALL cover flush and a mid-operation valid: flush at accept+10 -> no done, busy=0 next cycle, Result retains its prior value; a new valid_i while busy -> ignored.
REQ-038 Bench SHALL cover reset mid-operation and non-M requests: rst_n low at accept+5 -> outputs zero asynchronously, then a new MUL 3*4 -> 12; ALUOp=2'b10 with Funct7=0 -> no accept, busy stays 0.
